montacarga_scheduler: RTL

MONTACARGA_SCHEDULER -- requirements
Module: montacarga_scheduler

---
 rtl/montacarga_scheduler_if.sv | 17 +
 rtl/montacarga_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/montacarga_scheduler_if.sv
// Cab-side signal bundle of the montacarga scheduler: call buttons and limit
// switches in, motor command and status out.
interface montacarga_scheduler_if;
    logic       P1, P2, P3;
    logic       FC1, FC2, FC3;
    logic       S0, S1;
    logic       enable;
    logic       door_open;
    logic [2:0] pending;
    logic       fault;
    logic [6:0] Display;

    modport master (output P1, P2, P3, FC1, FC2, FC3,
                    input  S0, S1, enable, door_open, pending, fault, Display);
    modport slave  (input  P1, P2, P3, FC1, FC2, FC3,
                    output S0, S1, enable, door_open, pending, fault, Display);
endinterface

// File: rtl/montacarga_scheduler.sv
// Three-floor goods-lift scheduler: latches floor calls, drives the hoist motor
// toward them, holds the door for a dwell period and latches a fault on bad sensing.
module montacarga_scheduler #(
    parameter int DWELL          = 8,
    parameter int TRAVEL_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    montacarga_scheduler_if.slave  bus
);
    // IDLE: waiting | MOVE_UP/MOVE_DOWN: motor on | DOOR: dwell at floor | FAULT: latched until reset
    typedef enum logic [2:0] {ST_IDLE, ST_MOVE_UP, ST_MOVE_DOWN, ST_DOOR, ST_FAULT} state_t;

    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam int TW = (TRAVEL_TIMEOUT > 1) ? $clog2(TRAVEL_TIMEOUT) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TIMEOUT - 1);
    localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL - 1);

    state_t        r_state;
    logic [1:0]    r_cur;
    logic          r_dir_up;
    logic [2:0]    r_pending;
    logic [TW-1:0] r_travel;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_s;
    logic          r_enable;
    logic          r_door;
    logic          r_fault;
    logic [6:0]    r_display;

    logic [2:0] w_fc;
    logic [2:0] w_call;
    logic       w_multi_fc;
    logic [2:0] w_cur_mask;
    logic [2:0] w_above;
    logic [2:0] w_below;
    logic [2:0] w_req_set;
    logic [2:0] w_pend_merged;
    logic       w_moving;
    logic [1:0] w_next_floor;
    logic [2:0] w_next_mask;
    logic [2:0] w_beyond;
    logic       w_valid;
    logic       w_stop;
    logic       w_go_fault;

    function automatic logic [6:0] f_seg(input logic [1:0] floor);
        case (floor)
            2'd2:    return SEG_2;
            2'd3:    return SEG_3;
            default: return SEG_1;
        endcase
    endfunction

    assign w_fc       = {bus.FC3, bus.FC2, bus.FC1};
    assign w_call     = {bus.P3, bus.P2, bus.P1};
    assign w_multi_fc = (w_fc[0] & w_fc[1]) | (w_fc[0] & w_fc[2]) | (w_fc[1] & w_fc[2]);

    always_comb begin
        w_cur_mask = 3'b001;
        w_above    = 3'b110;
        w_below    = 3'b000;
        case (r_cur)
            2'd2: begin w_cur_mask = 3'b010; w_above = 3'b100; w_below = 3'b001; end
            2'd3: begin w_cur_mask = 3'b100; w_above = 3'b000; w_below = 3'b011; end
            default: ;
        endcase
    end

    // A call for the floor whose door is already open is simply dropped.
    assign w_req_set     = w_call & ~((r_state == ST_DOOR) ? w_cur_mask : 3'b000);
    assign w_pend_merged = r_pending | w_req_set;

    assign w_moving     = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    assign w_next_floor = (r_state == ST_MOVE_UP) ? r_cur + 2'd1 : r_cur - 2'd1;
    assign w_next_mask  = (r_state == ST_MOVE_UP) ? {w_cur_mask[1:0], 1'b0} : {1'b0, w_cur_mask[2:1]};
    assign w_beyond     = ((r_state == ST_MOVE_UP) ? w_above : w_below) & ~w_next_mask;
    assign w_valid      = w_moving && |(w_fc & w_next_mask);
    assign w_stop       = |(r_pending & w_next_mask) || !(|(r_pending & w_beyond));
    assign w_go_fault   = w_multi_fc || (w_moving && !w_valid && r_travel == TRAVEL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cur     <= 2'd1;
            r_dir_up  <= 1'b1;
            r_pending <= 3'b000;
            r_travel  <= '0;
            r_dwell   <= '0;
            r_s       <= 2'b00;
            r_enable  <= 1'b0;
            r_door    <= 1'b0;
            r_fault   <= 1'b0;
            r_display <= SEG_1;
        end else if (r_state != ST_FAULT) begin
            r_pending <= w_pend_merged;
            if (w_go_fault) begin
                r_state   <= ST_FAULT;
                r_s       <= 2'b00;
                r_enable  <= 1'b0;
                r_door    <= 1'b0;
                r_fault   <= 1'b1;
                r_display <= SEG_E;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (|(r_pending & w_cur_mask)) begin
                            r_state   <= ST_DOOR;
                            r_pending <= w_pend_merged & ~w_cur_mask;
                            r_door    <= 1'b1;
                            r_dwell   <= '0;
                        end else if (|(r_pending & w_above) && (r_dir_up || !(|(r_pending & w_below)))) begin
                            r_state  <= ST_MOVE_UP;
                            r_dir_up <= 1'b1;
                            r_travel <= '0;
                            r_s      <= 2'b01;
                            r_enable <= 1'b1;
                        end else if (|(r_pending & w_below)) begin
                            r_state  <= ST_MOVE_DOWN;
                            r_dir_up <= 1'b0;
                            r_travel <= '0;
                            r_s      <= 2'b10;
                            r_enable <= 1'b1;
                        end
                    end
                    ST_MOVE_UP, ST_MOVE_DOWN: begin
                        if (w_valid) begin
                            r_cur     <= w_next_floor;
                            r_display <= f_seg(w_next_floor);
                            r_travel  <= '0;
                            if (w_stop) begin
                                r_state   <= ST_DOOR;
                                r_pending <= w_pend_merged & ~w_next_mask;
                                r_s       <= 2'b00;
                                r_enable  <= 1'b0;
                                r_door    <= 1'b1;
                                r_dwell   <= '0;
                            end
                        end else begin
                            r_travel <= r_travel + TW'(1);
                        end
                    end
                    ST_DOOR: begin
                        if (r_dwell == DWELL_LAST) begin
                            r_state <= ST_IDLE;
                            r_door  <= 1'b0;
                        end else begin
                            r_dwell <= r_dwell + DW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.S0        = r_s[0];
    assign bus.S1        = r_s[1];
    assign bus.enable    = r_enable;
    assign bus.door_open = r_door;
    assign bus.pending   = r_pending;
    assign bus.fault     = r_fault;
    assign bus.Display   = r_display;
endmodule
